priv_timer_irq: RTL and testbench

//  Machine timer / software-interrupt source (CLINT-style) feeding the timer_int and

---
 rtl/priv_timer_irq.sv | 131 +++++++++++++
 tb/tb_priv_timer_irq.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/priv_timer_irq.sv
// Machine timer / software-interrupt source: 64-bit mtime and mtimecmp, 1-bit msip,
// a word-wide register port and registered level interrupts toward the privilege block.
module priv_timer_irq #(
    parameter int unsigned PRESCALE = 1,
    parameter logic [63:0] TIME_RST = 64'h0
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        req,
    input  logic        wen,
    input  logic [4:0]  addr,
    input  logic [3:0]  byte_en,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ack,
    output logic        err,
    input  logic        freeze,
    output logic        timer_int,
    output logic        soft_int
);
    localparam int unsigned CNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(PRESCALE - 1);

    typedef enum logic {
        IDLE = 1'b0,
        RESP = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic             accept;
    logic             sel_msip, sel_cmp_lo, sel_cmp_hi, sel_time_lo, sel_time_hi;
    logic             hit, wr, tick;
    logic [31:0]      rd_val;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [63:0]      mtime_q, mtime_d;
    logic [63:0]      mtimecmp_q, mtimecmp_d;
    logic             msip_q, msip_d;

    function automatic logic [31:0] merge(input logic [31:0] old,
                                          input logic [31:0] data,
                                          input logic [3:0]  be);
        logic [31:0] res;
        res = old;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) res[8*b +: 8] = data[8*b +: 8];
        end
        return res;
    endfunction

    // Access FSM: state register
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Access FSM: next state; the response cycle never re-samples req
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (req) state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Access FSM: accept strobe
    always_comb begin
        accept = 1'b0;
        if (state_q == IDLE) accept = req;
    end

    // Address decode, read mux and prescaler
    always_comb begin
        sel_msip    = (addr == 5'h00);
        sel_cmp_lo  = (addr == 5'h08);
        sel_cmp_hi  = (addr == 5'h0C);
        sel_time_lo = (addr == 5'h10);
        sel_time_hi = (addr == 5'h14);
        hit = sel_msip | sel_cmp_lo | sel_cmp_hi | sel_time_lo | sel_time_hi;
        wr  = accept && wen && hit && (byte_en != 4'b0000);

        rd_val = 32'h0;
        if (sel_msip)    rd_val = {31'b0, msip_q};
        if (sel_cmp_lo)  rd_val = mtimecmp_q[31:0];
        if (sel_cmp_hi)  rd_val = mtimecmp_q[63:32];
        if (sel_time_lo) rd_val = mtime_q[31:0];
        if (sel_time_hi) rd_val = mtime_q[63:32];

        tick  = !freeze && (cnt_q == CNT_MAX);
        cnt_d = cnt_q;
        if (!freeze) cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
    end

    // Register updates; a write to either mtime half swallows that cycle's tick
    always_comb begin
        mtime_d    = mtime_q;
        mtimecmp_d = mtimecmp_q;
        msip_d     = msip_q;
        if (wr && sel_time_lo)      mtime_d[31:0]  = merge(mtime_q[31:0], wdata, byte_en);
        else if (wr && sel_time_hi) mtime_d[63:32] = merge(mtime_q[63:32], wdata, byte_en);
        else if (tick)              mtime_d = mtime_q + 64'd1;
        if (wr && sel_cmp_lo) mtimecmp_d[31:0]  = merge(mtimecmp_q[31:0], wdata, byte_en);
        if (wr && sel_cmp_hi) mtimecmp_d[63:32] = merge(mtimecmp_q[63:32], wdata, byte_en);
        if (wr && sel_msip && byte_en[0]) msip_d = wdata[0];
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            mtime_q    <= TIME_RST;
            mtimecmp_q <= '1;
            msip_q     <= 1'b0;
            cnt_q      <= '0;
            rdata      <= 32'h0;
            ack        <= 1'b0;
            err        <= 1'b0;
            timer_int  <= 1'b0;
            soft_int   <= 1'b0;
        end else begin
            mtime_q    <= mtime_d;
            mtimecmp_q <= mtimecmp_d;
            msip_q     <= msip_d;
            cnt_q      <= cnt_d;
            ack        <= accept;
            err        <= accept && !hit;
            rdata      <= (accept && !wen && hit) ? rd_val : 32'h0;
            timer_int  <= (mtime_q >= mtimecmp_q);
            soft_int   <= msip_q;
        end
    end

endmodule

// File: tb/tb_priv_timer_irq.sv
// Bench for priv_timer_irq: two instances (PRESCALE 1 and 4) driven by one bus and
// checked every cycle against a 64-bit arithmetic model of the timer.
module tb_priv_timer_irq;
    localparam logic [63:0] RST_A = 64'h0;
    localparam logic [63:0] RST_B = 64'h0000_0001_0000_0020;

    logic        CLK = 1'b0;
    logic        nRST, req, wen, freeze;
    logic [4:0]  addr;
    logic [3:0]  byte_en;
    logic [31:0] wdata;
    logic [31:0] rdata_a, rdata_b;
    logic        ack_a, ack_b, err_a, err_b, ti_a, ti_b, si_a, si_b;

    priv_timer_irq #(.PRESCALE(1), .TIME_RST(RST_A)) u_a (
        .CLK(CLK), .nRST(nRST), .req(req), .wen(wen), .addr(addr), .byte_en(byte_en),
        .wdata(wdata), .rdata(rdata_a), .ack(ack_a), .err(err_a), .freeze(freeze),
        .timer_int(ti_a), .soft_int(si_a));

    priv_timer_irq #(.PRESCALE(4), .TIME_RST(RST_B)) u_b (
        .CLK(CLK), .nRST(nRST), .req(req), .wen(wen), .addr(addr), .byte_en(byte_en),
        .wdata(wdata), .rdata(rdata_b), .ack(ack_b), .err(err_b), .freeze(freeze),
        .timer_int(ti_b), .soft_int(si_b));

    always #5 CLK = ~CLK;

    int unsigned n_assert = 0;
    int unsigned n_fail   = 0;

    int unsigned ps [2] = '{1, 4};
    logic [63:0] m_time [2];
    logic [63:0] m_cmp  [2];
    logic        m_msip [2];
    int unsigned m_cnt  [2];
    logic        m_busy;
    logic        e_ti [2];
    logic        e_si [2];
    logic [31:0] e_rd [2];
    logic        e_ack, e_err, e_rd_chk;

    logic [4:0]  addr_tab [10] = '{5'h00, 5'h04, 5'h08, 5'h0C, 5'h10,
                                   5'h14, 5'h18, 5'h1C, 5'h09, 5'h02};

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("ack_a", 64'(ack_a), 64'(e_ack));
        chk("ack_b", 64'(ack_b), 64'(e_ack));
        chk("err_a", 64'(err_a), 64'(e_err));
        chk("err_b", 64'(err_b), 64'(e_err));
        if (e_rd_chk) begin
            chk("rdata_a", 64'(rdata_a), 64'(e_rd[0]));
            chk("rdata_b", 64'(rdata_b), 64'(e_rd[1]));
        end
        chk("timer_int_a", 64'(ti_a), 64'(e_ti[0]));
        chk("timer_int_b", 64'(ti_b), 64'(e_ti[1]));
        chk("soft_int_a", 64'(si_a), 64'(e_si[0]));
        chk("soft_int_b", 64'(si_b), 64'(e_si[1]));
    endtask

    function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] d,
                                          input logic [3:0] be);
        for (int b = 0; b < 4; b++) if (be[b]) o[8*b +: 8] = d[8*b +: 8];
        return o;
    endfunction

    // One clock edge: predict from current inputs, then compare just after the edge.
    task automatic step();
        logic acc, hit;
        acc    = req && !m_busy;
        m_busy = acc;
        hit    = addr inside {5'h00, 5'h08, 5'h0C, 5'h10, 5'h14};
        e_ack  = acc;
        e_err  = acc && !hit;
        e_rd_chk = acc && !wen;
        for (int i = 0; i < 2; i++) begin
            logic tick;
            e_ti[i] = (m_time[i] >= m_cmp[i]);
            e_si[i] = m_msip[i];
            case (addr)
                5'h00:   e_rd[i] = {31'b0, m_msip[i]};
                5'h08:   e_rd[i] = m_cmp[i][31:0];
                5'h0C:   e_rd[i] = m_cmp[i][63:32];
                5'h10:   e_rd[i] = m_time[i][31:0];
                5'h14:   e_rd[i] = m_time[i][63:32];
                default: e_rd[i] = 32'h0;
            endcase
            tick = 1'b0;
            if (!freeze) begin
                if (m_cnt[i] == ps[i] - 1) begin
                    m_cnt[i] = 0;
                    tick = 1'b1;
                end else begin
                    m_cnt[i]++;
                end
            end
            if (acc && wen && hit && byte_en != 4'b0000) begin
                case (addr)
                    5'h00: if (byte_en[0]) m_msip[i] = wdata[0];
                    5'h08: m_cmp[i][31:0]  = merge(m_cmp[i][31:0], wdata, byte_en);
                    5'h0C: m_cmp[i][63:32] = merge(m_cmp[i][63:32], wdata, byte_en);
                    5'h10: begin m_time[i][31:0]  = merge(m_time[i][31:0], wdata, byte_en);  tick = 1'b0; end
                    5'h14: begin m_time[i][63:32] = merge(m_time[i][63:32], wdata, byte_en); tick = 1'b0; end
                    default: ;
                endcase
            end
            if (tick) m_time[i] = m_time[i] + 64'd1;
        end
        @(posedge CLK);
        #1;
        check_all();
    endtask

    task automatic access(input logic w, input logic [4:0] a, input logic [3:0] be,
                          input logic [31:0] d);
        req = 1'b1; wen = w; addr = a; byte_en = be; wdata = d;
        step();
        req = 1'b0; wen = 1'b0;
        step();
    endtask

    task automatic do_reset();
        req  = 1'b0;
        nRST = 1'b0;
        #1;
        m_time = '{RST_A, RST_B};
        m_cmp  = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF};
        m_msip = '{1'b0, 1'b0};
        m_cnt  = '{0, 0};
        m_busy = 1'b0;
        e_ti = '{1'b0, 1'b0};
        e_si = '{1'b0, 1'b0};
        e_rd = '{32'h0, 32'h0};
        e_ack = 1'b0; e_err = 1'b0; e_rd_chk = 1'b1;
        check_all();
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        nRST = 1'b1;
    endtask

    initial begin
        req = 1'b0; wen = 1'b0; addr = 5'h0; byte_en = 4'h0; wdata = 32'h0; freeze = 1'b0;
        nRST = 1'b0;
        do_reset();

        // Free-running count, then mtime readback
        repeat (5) step();
        access(1'b0, 5'h10, 4'hF, 32'h0);
        access(1'b0, 5'h14, 4'hF, 32'h0);

        // Compare threshold: raise, then clear by lifting mtimecmp
        access(1'b1, 5'h0C, 4'hF, 32'h0);
        access(1'b1, 5'h08, 4'hF, 32'h10);
        repeat (12) step();
        access(1'b1, 5'h08, 4'hF, 32'hFFFF_FFFF);
        repeat (2) step();

        // Carry from low to high word
        access(1'b1, 5'h14, 4'hF, 32'h0);
        access(1'b1, 5'h10, 4'hF, 32'hFFFF_FFFF);
        access(1'b0, 5'h10, 4'hF, 32'h0);
        access(1'b0, 5'h14, 4'hF, 32'h0);

        // Software interrupt and empty byte enables
        access(1'b1, 5'h00, 4'b0001, 32'h1);
        step();
        access(1'b1, 5'h00, 4'b0000, 32'h0);
        access(1'b1, 5'h00, 4'b1110, 32'hFFFF_FFFE);
        access(1'b0, 5'h00, 4'hF, 32'h0);

        // Unmapped and misaligned accesses
        access(1'b0, 5'h04, 4'hF, 32'h0);
        access(1'b0, 5'h09, 4'hF, 32'h0);
        access(1'b1, 5'h1C, 4'hF, 32'h1234_5678);
        access(1'b1, 5'h12, 4'hF, 32'h1234_5678);

        // Held request: a new access only after the response cycle
        req = 1'b1; wen = 1'b0; addr = 5'h10; byte_en = 4'hF;
        repeat (4) step();
        req = 1'b0;
        step();

        // Debug freeze
        freeze = 1'b1;
        repeat (10) step();
        access(1'b0, 5'h10, 4'hF, 32'h0);
        access(1'b1, 5'h10, 4'h3, 32'hABCD_0123);
        freeze = 1'b0;
        access(1'b0, 5'h10, 4'hF, 32'h0);

        // Randomized traffic
        for (int n = 0; n < 300; n++) begin
            freeze = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 2) == 0) begin
                step();
            end else begin
                access(1'($urandom_range(0, 1)), addr_tab[$urandom_range(0, 9)],
                       4'($urandom), $urandom);
            end
        end
        freeze = 1'b0;

        // Reset asserted during the response cycle
        req = 1'b1; wen = 1'b1; addr = 5'h00; byte_en = 4'b0001; wdata = 32'h1;
        step();
        do_reset();
        repeat (3) step();
        access(1'b0, 5'h00, 4'hF, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
